// File: rtl/jtframe_lfbuf_obj_pkg.sv
// Shared constants for the object line renderer: object entry field layout,
// object geometry and the FSM state encoding.
package jtframe_lfbuf_obj_pkg;

  localparam int ENTRY_W      = 32;
  localparam int ROM_AW       = 14;
  localparam int Y_LSB        = 0;
  localparam int X_LSB        = 8;
  localparam int CODE_LSB     = 17;
  localparam int PAL_LSB      = 26;
  localparam int HFLIP_BIT    = 30;
  localparam int EN_BIT       = 31;
  localparam int OBJ_SIZE     = 16;
  localparam int PXL_PER_WORD = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RDOBJ,
    ST_CHECK,
    ST_FETCH,
    ST_DRAW,
    ST_NEXT,
    ST_DONE
  } state_e;

  // Row distance from the object's top edge, wrapping over the 256-line space
  function automatic logic [7:0] obj_dy(input logic [7:0] line, input logic [7:0] y);
    return line - y;
  endfunction

endpackage

// File: rtl/jtframe_lfbuf_obj_draw_if.sv
// Bundle of line-buffer write port, object-table port and pixel-ROM port.
// The master side is the renderer.
interface jtframe_lfbuf_obj_draw_if #(
  parameter int DW = 16,
  parameter int VW = 8,
  parameter int HW = 9,
  parameter int OW = 5
);
  import jtframe_lfbuf_obj_pkg::*;

  logic                ln_hs;
  logic [VW-1:0]       ln_v;
  logic [HW-1:0]       ln_addr;
  logic [DW-1:0]       ln_data;
  logic                ln_we;
  logic                ln_done;
  logic [OW-1:0]       obj_addr;
  logic [ENTRY_W-1:0]  obj_data;
  logic                rom_cs;
  logic [ROM_AW-1:0]   rom_addr;
  logic [31:0]         rom_data;
  logic                rom_ok;
  logic                busy;

  modport master (
    input  ln_hs, ln_v, obj_data, rom_data, rom_ok,
    output ln_addr, ln_data, ln_we, ln_done, obj_addr, rom_cs, rom_addr, busy
  );

  modport slave (
    output ln_hs, ln_v, obj_data, rom_data, rom_ok,
    input  ln_addr, ln_data, ln_we, ln_done, obj_addr, rom_cs, rom_addr, busy
  );

endinterface

// File: rtl/jtframe_lfbuf_obj_pxl.sv
// Holds the latched 8-pixel ROM word and picks the nibble for the current
// column, mirrored when the object is horizontally flipped.
module jtframe_lfbuf_obj_pxl
  import jtframe_lfbuf_obj_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [31:0] word_i,
  input  logic [2:0]  col_i,
  input  logic        flip_i,
  output logic [3:0]  pxl_o,
  output logic        opaque_o
);

  logic [31:0] word_q;
  logic [3:0]  nib [PXL_PER_WORD];
  logic [2:0]  sel;

  always_ff @(posedge clk) begin
    if (rst)         word_q <= '0;
    else if (load_i) word_q <= word_i;
  end

  genvar gi;
  generate
    for (gi = 0; gi < PXL_PER_WORD; gi++) begin : g_nib
      assign nib[gi] = word_q[4*gi +: 4];
    end
  endgenerate

  assign sel      = flip_i ? 3'(PXL_PER_WORD - 1) - col_i : col_i;
  assign pxl_o    = nib[sel];
  assign opaque_o = |pxl_o;

endmodule

// File: rtl/jtframe_lfbuf_obj_draw.sv
// Object line renderer: clears a line, walks the object table and draws the
// visible 16x16 objects' pixels into the line buffer write port.
module jtframe_lfbuf_obj_draw
  import jtframe_lfbuf_obj_pkg::*;
#(
  parameter int            DW = 16,
  parameter int            VW = 8,
  parameter int            HW = 9,
  parameter int            OW = 5,
  parameter logic [DW-1:0] BG = '0
) (
  input logic                    clk,
  input logic                    rst,
  jtframe_lfbuf_obj_draw_if.master bus
);

  state_e        state_q, state_d;
  logic          hs_q;
  logic          start;
  logic [VW-1:0] v_q;
  logic [HW-1:0] cnt_q;
  logic [OW-1:0] idx_q;
  logic [2:0]    col_q;
  logic          half_q;
  logic [8:0]    x_q, code_q;
  logic [3:0]    pal_q, row_q;
  logic          hflip_q;
  logic [7:0]    dy;
  logic          hit, rom_take;
  logic          ln_we_q, ln_we_d;
  logic [HW-1:0] ln_addr_q, ln_addr_d;
  logic [DW-1:0] ln_data_q, ln_data_d;
  logic          done_q, done_d, busy_q, busy_d, rom_cs_q, rom_cs_d;
  logic [3:0]    pxl;
  logic          opaque;

  // A new request always wins, even mid-line: the old line is dropped silently
  assign start    = bus.ln_hs & ~hs_q;
  assign dy       = obj_dy(v_q[7:0], bus.obj_data[Y_LSB +: 8]);
  assign hit      = bus.obj_data[EN_BIT] && (dy < 8'(OBJ_SIZE));
  assign rom_take = rom_cs_q & bus.rom_ok;

  jtframe_lfbuf_obj_pxl u_pxl (
    .clk      (clk),
    .rst      (rst),
    .load_i   (rom_take),
    .word_i   (bus.rom_data),
    .col_i    (col_q),
    .flip_i   (hflip_q),
    .pxl_o    (pxl),
    .opaque_o (opaque)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      hs_q      <= 1'b0;
      ln_we_q   <= 1'b0;
      ln_addr_q <= '0;
      ln_data_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      rom_cs_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      hs_q      <= bus.ln_hs;
      ln_we_q   <= ln_we_d;
      ln_addr_q <= ln_addr_d;
      ln_data_q <= ln_data_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      rom_cs_q  <= rom_cs_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ST_CLEAR;
    end else begin
      case (state_q)
        ST_CLEAR: if (&cnt_q) state_d = ST_RDOBJ;
        ST_RDOBJ: state_d = ST_CHECK;
        ST_CHECK: state_d = hit ? ST_FETCH : ST_NEXT;
        ST_FETCH: if (rom_take) state_d = ST_DRAW;
        ST_DRAW:  if (&col_q) state_d = half_q ? ST_NEXT : ST_FETCH;
        ST_NEXT:  state_d = (&idx_q) ? ST_DONE : ST_RDOBJ;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ln_we_d   = 1'b0;
    ln_addr_d = ln_addr_q;
    ln_data_d = ln_data_q;
    done_d    = 1'b0;
    busy_d    = start || (state_q != ST_IDLE && state_q != ST_DONE);
    rom_cs_d  = (state_d == ST_FETCH);
    if (!start) begin
      case (state_q)
        ST_CLEAR: begin
          ln_we_d   = 1'b1;
          ln_addr_d = cnt_q;
          ln_data_d = BG;
        end
        ST_DRAW: begin
          ln_we_d   = opaque;
          ln_addr_d = HW'(x_q) + HW'({half_q, col_q});
          ln_data_d = DW'({pal_q, pxl});
        end
        ST_DONE: done_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q     <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      col_q   <= '0;
      half_q  <= 1'b0;
      x_q     <= '0;
      code_q  <= '0;
      pal_q   <= '0;
      row_q   <= '0;
      hflip_q <= 1'b0;
    end else if (start) begin
      v_q    <= bus.ln_v;
      cnt_q  <= '0;
      idx_q  <= '0;
      col_q  <= '0;
      half_q <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: cnt_q <= cnt_q + 1'b1;
        ST_CHECK: begin
          x_q     <= bus.obj_data[X_LSB +: 9];
          code_q  <= bus.obj_data[CODE_LSB +: 9];
          pal_q   <= bus.obj_data[PAL_LSB +: 4];
          hflip_q <= bus.obj_data[HFLIP_BIT];
          row_q   <= dy[3:0];
          half_q  <= 1'b0;
        end
        ST_FETCH: if (rom_take) col_q <= '0;
        ST_DRAW: begin
          col_q <= col_q + 1'b1;
          if (&col_q) half_q <= 1'b1;
        end
        ST_NEXT:  idx_q <= idx_q + 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.ln_we    = ln_we_q;
  assign bus.ln_addr  = ln_addr_q;
  assign bus.ln_data  = ln_data_q;
  assign bus.ln_done  = done_q;
  assign bus.busy     = busy_q;
  assign bus.rom_cs   = rom_cs_q;
  // Flipped objects fetch the right-hand ROM half first
  assign bus.rom_addr = {code_q, row_q, half_q ^ hflip_q};
  assign bus.obj_addr = idx_q;

endmodule

// File: tb/tb_jtframe_lfbuf_obj_draw.sv
// Directed bench for the object line renderer with an object RAM model,
// a pixel ROM model with programmable latency and a line-buffer monitor.
module tb_jtframe_lfbuf_obj_draw;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  jtframe_lfbuf_obj_draw_if bus_if ();

  jtframe_lfbuf_obj_draw dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  logic [31:0] obj_tab [32];
  logic [31:0] rom_w0, rom_w1;
  int          rom_delay = 0;
  int          rcnt = 0;

  always @(posedge clk) begin
    bus_if.obj_data <= obj_tab[bus_if.obj_addr];
    if (!bus_if.rom_cs) begin
      rcnt          <= 0;
      bus_if.rom_ok <= 1'b0;
    end else if (rcnt >= rom_delay) begin
      bus_if.rom_ok <= 1'b1;
    end else begin
      rcnt <= rcnt + 1;
    end
  end
  assign bus_if.rom_data = bus_if.rom_addr[0] ? rom_w1 : rom_w0;

  logic [15:0] lbuf    [512];
  logic [15:0] exp_buf [512];
  int          wr_cnt = 0, done_cnt = 0, done_all = 0;
  int          order_bad = 0, late_wr = 0, stab_bad = 0;
  logic        mon_clr = 1'b0, stab_en = 1'b0;
  logic        cs_prev = 1'b0, ok_prev = 1'b0;
  logic [13:0] addr_prev = '0;
  logic [13:0] req_q [$];

  always @(negedge clk) begin
    cs_prev   <= bus_if.rom_cs;
    ok_prev   <= bus_if.rom_ok;
    addr_prev <= bus_if.rom_addr;
    if (bus_if.ln_done) done_all <= done_all + 1;
    if (stab_en && cs_prev && !ok_prev &&
        (!bus_if.rom_cs || bus_if.rom_addr != addr_prev)) stab_bad <= stab_bad + 1;
    if (mon_clr) begin
      for (int i = 0; i < 512; i++) lbuf[i] <= 16'hFFFF;
      wr_cnt    <= 0;
      done_cnt  <= 0;
      order_bad <= 0;
      late_wr   <= 0;
      req_q.delete();
    end else begin
      if (bus_if.ln_we) begin
        lbuf[bus_if.ln_addr] <= bus_if.ln_data;
        wr_cnt <= wr_cnt + 1;
        if (wr_cnt < 512 && (int'(bus_if.ln_addr) != wr_cnt || bus_if.ln_data != 16'h0))
          order_bad <= order_bad + 1;
        if (done_cnt != 0 || bus_if.ln_done) late_wr <= late_wr + 1;
      end
      if (bus_if.ln_done) done_cnt <= done_cnt + 1;
      if (bus_if.rom_cs && !cs_prev) req_q.push_back(bus_if.rom_addr);
    end
  end

  int n_chk = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_obj(input logic en, input logic hf, input logic [3:0] pal,
                                         input logic [8:0] code, input logic [8:0] x,
                                         input logic [7:0] y);
    return {en, hf, pal, code, x, y};
  endfunction

  function automatic int buf_diff();
    int d = 0;
    for (int i = 0; i < 512; i++) if (lbuf[i] !== exp_buf[i]) d++;
    return d;
  endfunction

  task automatic exp_clear();
    for (int i = 0; i < 512; i++) exp_buf[i] = 16'h0;
  endtask

  task automatic tab_clear();
    for (int i = 0; i < 32; i++) obj_tab[i] = 32'h0;
  endtask

  task automatic start_line(input logic [7:0] v);
    @(posedge clk); #1;
    mon_clr = 1'b1;
    bus_if.ln_v = v;
    bus_if.ln_hs = 1'b1;
    @(posedge clk); #1;
    mon_clr = 1'b0;
    @(posedge clk); #1;
    bus_if.ln_hs = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_cnt == 0 && n < 4000) begin
      @(posedge clk);
      n++;
    end
    check({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    $display("line %s: v=%0d writes=%0d done=%0d roms=%0d", tag, bus_if.ln_v, wr_cnt,
             done_cnt, req_q.size());
  endtask

  task automatic wait_rom_cs(input string tag);
    int n = 0;
    while (!bus_if.rom_cs && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rom_cs_seen"}, 32'(bus_if.rom_cs), 32'd1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int d0;
    int n;
    rst = 1'b1;
    bus_if.ln_hs = 1'b0;
    bus_if.ln_v = '0;
    rom_w0 = 32'h0;
    rom_w1 = 32'h0;
    tab_clear();
    repeat (4) @(posedge clk);
    #1;
    check("rst_we", 32'(bus_if.ln_we), 32'd0);
    check("rst_done", 32'(bus_if.ln_done), 32'd0);
    check("rst_busy", 32'(bus_if.busy), 32'd0);
    check("rst_rom_cs", 32'(bus_if.rom_cs), 32'd0);
    check("rst_addrs", 32'({bus_if.ln_addr, bus_if.obj_addr, bus_if.rom_addr}), 32'd0);
    rst = 1'b0;

    // empty table: clear only
    exp_clear();
    start_line(8'd0);
    check("t1_first_we", 32'(bus_if.ln_we), 32'd1);
    check("t1_first_addr", 32'(bus_if.ln_addr), 32'd0);
    check("t1_busy", 32'(bus_if.busy), 32'd1);
    wait_done("t1");
    check("t1_writes", wr_cnt, 32'd512);
    check("t1_order", order_bad, 32'd0);
    check("t1_buf", buf_diff(), 32'd0);
    check("t1_done_cnt", done_cnt, 32'd1);
    check("t1_late_wr", late_wr, 32'd0);
    check("t1_busy_end", 32'(bus_if.busy), 32'd0);

    // single object, row 2
    obj_tab[0] = mk_obj(1'b1, 1'b0, 4'd5, 9'd3, 9'd100, 8'd10);
    rom_w0 = 32'h87654321;
    rom_w1 = 32'h87654321;
    exp_clear();
    for (int i = 0; i < 16; i++) exp_buf[100+i] = 16'h51 + 16'(i % 8);
    start_line(8'd12);
    wait_done("t2");
    check("t2_writes", wr_cnt, 32'd528);
    check("t2_buf", buf_diff(), 32'd0);
    check("t2_px100", 32'(lbuf[100]), 32'h51);
    check("t2_px115", 32'(lbuf[115]), 32'h58);
    check("t2_nreq", req_q.size(), 32'd2);
    check("t2_req0", 32'(req_q[0]), 32'h64);
    check("t2_req1", 32'(req_q[1]), 32'h65);
    check("t2_late_wr", late_wr, 32'd0);

    // hflip
    obj_tab[0] = mk_obj(1'b1, 1'b1, 4'd5, 9'd3, 9'd100, 8'd10);
    exp_clear();
    for (int i = 0; i < 16; i++) exp_buf[100+i] = 16'h58 - 16'(i % 8);
    start_line(8'd12);
    wait_done("t3");
    check("t3_buf", buf_diff(), 32'd0);
    check("t3_px100", 32'(lbuf[100]), 32'h58);
    check("t3_px107", 32'(lbuf[107]), 32'h51);
    check("t3_req0", 32'(req_q[0]), 32'h65);
    check("t3_req1", 32'(req_q[1]), 32'h64);

    // wrap-around and transparent pixels
    obj_tab[0] = mk_obj(1'b1, 1'b0, 4'd2, 9'd3, 9'd508, 8'd0);
    rom_w0 = 32'h0A0B0C0D;
    rom_w1 = 32'h12345678;
    exp_clear();
    exp_buf[508] = 16'h2D;
    exp_buf[510] = 16'h2C;
    exp_buf[0]   = 16'h2B;
    exp_buf[2]   = 16'h2A;
    for (int i = 0; i < 8; i++) exp_buf[4+i] = 16'h28 - 16'(i);
    start_line(8'd5);
    wait_done("t4");
    check("t4_writes", wr_cnt, 32'd524);
    check("t4_buf", buf_diff(), 32'd0);
    check("t4_px0", 32'(lbuf[0]), 32'h2B);
    check("t4_px1", 32'(lbuf[1]), 32'h0);
    check("t4_px11", 32'(lbuf[11]), 32'h21);
    check("t4_req0", 32'(req_q[0]), 32'h6A);

    // priority, dy wrap, dy=15 hit, dy=16 miss, disabled entry
    tab_clear();
    obj_tab[2] = mk_obj(1'b1, 1'b0, 4'd1, 9'd4, 9'd200, 8'd250);
    obj_tab[3] = mk_obj(1'b1, 1'b0, 4'd3, 9'd4, 9'd300, 8'd20);
    obj_tab[4] = mk_obj(1'b1, 1'b0, 4'd3, 9'd4, 9'd300, 8'd243);
    obj_tab[5] = mk_obj(1'b0, 1'b0, 4'd3, 9'd4, 9'd300, 8'd0);
    obj_tab[6] = mk_obj(1'b1, 1'b0, 4'd6, 9'd4, 9'd400, 8'd244);
    obj_tab[7] = mk_obj(1'b1, 1'b0, 4'd7, 9'd4, 9'd200, 8'd250);
    rom_w0 = 32'h11111111;
    rom_w1 = 32'h11111111;
    exp_clear();
    for (int i = 0; i < 16; i++) begin
      exp_buf[200+i] = 16'h71;
      exp_buf[400+i] = 16'h61;
    end
    start_line(8'd3);
    wait_done("t5");
    check("t5_writes", wr_cnt, 32'd560);
    check("t5_buf", buf_diff(), 32'd0);
    check("t5_px200", 32'(lbuf[200]), 32'h71);
    check("t5_px415", 32'(lbuf[415]), 32'h61);
    check("t5_nreq", req_q.size(), 32'd6);
    check("t5_req0", 32'(req_q[0]), 32'h92);
    check("t5_req2", 32'(req_q[2]), 32'h9E);

    // abort mid-draw, new line has no hits
    tab_clear();
    obj_tab[0] = mk_obj(1'b1, 1'b0, 4'd5, 9'd3, 9'd100, 8'd10);
    rom_w0 = 32'h87654321;
    rom_w1 = 32'h87654321;
    d0 = done_all;
    start_line(8'd12);
    n = 0;
    while (!(bus_if.ln_we && bus_if.ln_addr == 9'd100 && wr_cnt >= 512) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("t6_draw_seen", 32'(n < 2000), 32'd1);
    exp_clear();
    start_line(8'd40);
    wait_done("t6");
    check("t6_done_total", done_all - d0, 32'd1);
    check("t6_writes", wr_cnt, 32'd512);
    check("t6_buf", buf_diff(), 32'd0);

    // slow ROM, abort during the wait, then complete with the new line
    rom_delay = 20;
    d0 = done_all;
    stab_en = 1'b1;
    start_line(8'd12);
    wait_rom_cs("t7a");
    check("t7_wait_addr", 32'(bus_if.rom_addr), 32'h64);
    repeat (15) @(negedge clk);
    check("t7_still_cs", 32'(bus_if.rom_cs), 32'd1);
    stab_en = 1'b0;
    check("t7_stab_a", stab_bad, 32'd0);
    start_line(8'd13);
    stab_en = 1'b1;
    exp_clear();
    for (int i = 0; i < 16; i++) exp_buf[100+i] = 16'h51 + 16'(i % 8);
    wait_done("t7");
    stab_en = 1'b0;
    check("t7_done_total", done_all - d0, 32'd1);
    check("t7_req0", 32'(req_q[0]), 32'h66);
    check("t7_writes", wr_cnt, 32'd528);
    check("t7_buf", buf_diff(), 32'd0);
    check("t7_stab", stab_bad, 32'd0);

    // reset mid-line
    d0 = done_all;
    start_line(8'd12);
    wait_rom_cs("t8");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("t8_rom_cs", 32'(bus_if.rom_cs), 32'd0);
    check("t8_busy", 32'(bus_if.busy), 32'd0);
    rst = 1'b0;
    repeat (1200) @(posedge clk);
    #1;
    check("t8_no_done", done_all - d0, 32'd0);
    check("t8_idle_busy", 32'(bus_if.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/jtframe_lfbuf_obj_draw.md
# jtframe_lfbuf_obj_draw

Line renderer that sits directly upstream of the DDR line/frame buffer. On each `ln_hs` request it draws line `ln_v` into the buffer's write port (`ln_addr`/`ln_data`/`ln_we`), then signals `ln_done`. It clears the line first, walks an object table, fetches 4bpp pixel words from ROM and writes the non-transparent pixels. The frame buffer then moves the finished line to DDR.

## Interface
Parameters:
- `DW`, 16: pixel data width written to the buffer (≥ 8).
- `VW`, 8: line number width.
- `HW`, 9: pixel address width; the line is 2^HW pixels long.
- `OW`, 5: object index width; the table has 2^OW entries.
- `BG`, 0: colour written during the clear phase, DW bits.

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: synchronous, active-high reset.
- `ln_hs`  in  1: line request. The rising edge starts a line.
- `ln_v`  in  VW: line to draw, sampled on the `ln_hs` rising edge.
- `ln_addr`  out  HW: buffer write address.
- `ln_data`  out  DW: `{zeros, pal[3:0], pxl[3:0]}`; equals `BG` during the clear phase.
- `ln_we`  out  1: buffer write strobe, one pixel per cycle.
- `ln_done`  out  1: one-cycle pulse when the line is complete.
- `obj_addr`  out  OW: object table address.
- `obj_data`  in  32: object entry, valid 1 cycle after `obj_addr` (synchronous RAM).
- `rom_cs`  out  1: pixel ROM request.
- `rom_addr`  out  14: `{code[8:0], row[3:0], half}`.
- `rom_data`  in  32: 8 pixels, 4 bits each; nibble n is the n-th pixel from the left.
- `rom_ok`  in  1: `rom_data` valid for the current `rom_addr`.
- `busy`  out  1: high from the `ln_hs` edge until `ln_done`.

## Operation
- Entry layout: `[7:0]` y, `[16:8]` x, `[25:17]` code, `[29:26]` pal, `[30]` hflip, `[31]` enable. Objects are 16×16 pixels.
- States: IDLE → CLEAR → RDOBJ → CHECK → FETCH → DRAW → (FETCH for the second half | NEXT) → … → DONE → IDLE.
- CLEAR: writes `BG` to addresses 0 … 2^HW−1, one per cycle, `ln_we`=1.
- RDOBJ: drives `obj_addr`=idx; the entry is registered the next cycle.
- CHECK: computes dy = (ln_v[7:0] − y) mod 256. The object is a hit when enable=1 and dy < 16, and then row = dy[3:0]. A miss goes to NEXT.
- FETCH: half h ∈ {0,1}; ROM half = h XOR hflip. `rom_cs` is held high with a stable address until `rom_ok`=1. The word is latched on that cycle and `rom_cs` drops the next cycle.
- DRAW: 8 cycles, column c = 0…7.
  - Pixel = nibble c, or nibble 7−c when hflip=1.
  - `ln_addr` = (x + 8h + c) mod 2^HW; wrap-around is legal.
  - `ln_we`=1 only when the pixel ≠ 0; 0 is transparent.
- NEXT: idx+1. When idx wraps to 0 the state goes to DONE. Higher index overwrites lower, so the last object has priority.
- DONE: `ln_done`=1 for one cycle, `busy`=0, return to IDLE.
- A new `ln_hs` rising edge while `busy`=1 aborts the current line with no `ln_done`, samples the new `ln_v` and restarts at CLEAR.
- A `rom_ok` that arrives while `rom_cs`=0 is ignored.

## Timing
- Reset: all outputs 0, state IDLE, idx 0. A reset mid-line abandons the line with no `ln_done` and a deasserted `rom_cs` the next cycle.
- Line start: CLEAR begins on the cycle after the `ln_hs` edge is detected. The edge detector uses a registered `ln_hs`, so CLEAR writes address 0 two cycles after `ln_hs` rises.
- Cost:
  - CLEAR: 2^HW cycles.
  - Missed object: 2 cycles (RDOBJ + CHECK) plus 1 cycle NEXT.
  - Hit object: 3 + 2×(ROM wait + 1 + 8) cycles.
- `ln_done` rises 1 cycle after the last possible write. No `ln_we` occurs in the cycle of `ln_done` or after it.
- `ln_we`, `ln_addr` and `ln_data` are registered outputs and change together.

## Structure
- Package `jtframe_lfbuf_obj_pkg`: entry field offsets, `OBJ_SIZE`=16, `PXL_PER_WORD`=8, and the state encoding constants.
- Sub-module `jtframe_lfbuf_obj_pxl`: holds the latched ROM word and selects nibble c with the flip. It outputs the pixel and its opaque flag.

## Test plan
- Reset, then `ln_hs` with an all-disabled table and BG=0x0 → 512 writes of 0x0 at addresses 0…511, then a single `ln_done`. No other writes.
- One object at y=10, x=100, code=3, pal=5, ROM word 0x87654321 for both halves, `ln_v`=12 → row 2 requested (`rom_addr`={3,2,0} then {3,2,1}). Writes at 100…115 with data 0x51…0x58, repeated.
- Same object with hflip=1 → address 100 gets 0x58 and address 107 gets 0x51. The ROM half order is 1 then 0.
- Object at x=508 with pixel data containing zeros → writes wrap to addresses 0…11. Zero nibbles produce no `ln_we`.
- Objects 2 and 7 overlap at the same x → object 7's pixels are the last writes at the overlapping addresses. With y=250 and `ln_v`=3, dy=9 is a hit.
- `ln_hs` re-asserted mid-DRAW, and a separate case with `rom_ok` delayed 20 cycles → restart at CLEAR with the new `ln_v` and no `ln_done` for the aborted line. During the delay `rom_cs` and `rom_addr` stay stable.
